match_reporter: RTL and testbench

- Consumes the per-byte match elaboration handshake (match_found / password_byte / go) of the cracking core.
- Buffers one full cracked password of PW_BYTES bytes and optionally strips trailing pad characters.
- Streams the password, followed by a terminator byte, to a byte-wide valid/ready transmit interface (host UART TX).
- Sits directly downstream of ntcrackfpga. Its ack output is ORed at top level with the host start strobe to drive the core's go input.

---
 rtl/match_reporter.sv | 77 +++++++
 tb/tb_match_reporter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/match_reporter.sv
// match_reporter: buffers one cracked password from the core's byte handshake
// and streams it, pad-stripped, plus a terminator to a byte-wide tx interface.
module match_reporter #(
  parameter int         PW_BYTES   = 20,
  parameter logic [7:0] PAD_CHAR   = 8'h20,
  parameter bit         STRIP_PAD  = 1'b1,
  parameter logic [7:0] TERMINATOR = 8'h0A,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match_found,
  input  logic [7:0]       password_byte,
  output logic             ack,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] match_count
);
  localparam int IW = $clog2(PW_BYTES);
  localparam int LW = $clog2(PW_BYTES + 1);
  typedef enum logic [2:0] {ARM, WAIT_HI, ACK, WAIT_LO, SEND, TERM} state_t;
  state_t state, state_nx;
  logic [7:0] pw_buf [PW_BYTES];
  logic [IW-1:0] idx, k;
  logic [LW-1:0] len, send_len;
  logic armed, accept, last, capture;
  assign send_len = STRIP_PAD ? len : LW'(PW_BYTES);
  assign accept   = tx_valid && tx_ready;
  assign last     = idx == IW'(PW_BYTES - 1);
  assign capture  = state == WAIT_HI && armed && match_found;
  assign ack      = state == ACK;
  assign tx_valid = state == SEND || state == TERM;
  assign tx_data  = state == SEND ? pw_buf[k] : state == TERM ? TERMINATOR : 8'h00;
  always_comb begin
    state_nx = state;
    case (state)
      ARM:     state_nx = match_found ? ARM : WAIT_HI;
      WAIT_HI: state_nx = capture ? ACK : WAIT_HI;
      ACK:     state_nx = WAIT_LO;
      WAIT_LO: state_nx = match_found ? WAIT_LO : !last ? WAIT_HI : send_len == '0 ? TERM : SEND;
      SEND:    state_nx = accept && LW'(k) + LW'(1) == send_len ? TERM : SEND;
      TERM:    state_nx = accept ? WAIT_HI : TERM;
      default: state_nx = ARM;
    endcase
  end
  // Password storage carries no reset; it is always rewritten before being sent.
  always_ff @(posedge clk) begin
    if (capture) pw_buf[idx] <= password_byte;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARM;
      armed       <= 1'b0;
      idx         <= '0;
      k           <= '0;
      len         <= '0;
      busy        <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_nx;
      if (state == ARM && !match_found) armed <= 1'b1;
      if (capture) begin
        busy <= 1'b1;
        if (password_byte != PAD_CHAR) len <= LW'(idx) + LW'(1);
      end
      if (state == WAIT_LO && !match_found) idx <= last ? '0 : idx + IW'(1);
      if (state == SEND && accept) k <= state_nx == TERM ? '0 : k + IW'(1);
      if (state == TERM && accept) begin
        busy <= 1'b0;
        len  <= '0;
        if (~&match_count) match_count <= match_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_match_reporter.sv
// tb_match_reporter: directed test of match_reporter with a core-like byte
// handshake driver and tx scoreboards for stripped and unstripped variants.
module tb_match_reporter;
  typedef logic [7:0] pw_t [20];
  logic clk = 0, rst_n = 0, match_found = 0, np_en = 1;
  logic [7:0] password_byte = 0;
  logic rdy = 1, tog = 0, tog_en = 0, tx_ready;
  logic ack, tx_valid, busy, np_ack, np_tx_valid, np_busy;
  logic [7:0] tx_data, np_tx_data;
  logic [15:0] match_count, np_mc;
  logic [7:0] exp_q [$];
  logic [7:0] np_q [$];
  int n_cmp = 0, n_err = 0, ack_cnt = 0;
  logic stall = 0, np_stall = 0;
  logic [7:0] hold_d = 0, np_hold_d = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  assign tx_ready = tog_en ? tog : rdy;

  match_reporter dut (.clk(clk), .rst_n(rst_n), .match_found(match_found),
    .password_byte(password_byte), .ack(ack), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .match_count(match_count));
  match_reporter #(.STRIP_PAD(1'b0)) dut_np (.clk(clk), .rst_n(rst_n),
    .match_found(match_found && np_en), .password_byte(password_byte), .ack(np_ack),
    .tx_data(np_tx_data), .tx_valid(np_tx_valid), .tx_ready(tx_ready), .busy(np_busy),
    .match_count(np_mc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) ack_cnt++;
      if (tx_valid) chk("tx_valid_busy", busy, 1);
      if (stall) chk("tx_hold", {tx_valid, tx_data}, {1'b1, hold_d});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected", 0, 1);
        else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      stall  = tx_valid && !tx_ready;
      hold_d = tx_data;
      if (np_stall) chk("np_tx_hold", {np_tx_valid, np_tx_data}, {1'b1, np_hold_d});
      if (np_tx_valid && tx_ready) begin
        if (np_q.size() == 0) chk("np_tx_unexpected", 0, 1);
        else chk("np_tx_byte", np_tx_data, np_q.pop_front());
      end
      np_stall  = np_tx_valid && !tx_ready;
      np_hold_d = np_tx_data;
    end else begin
      stall    = 0;
      np_stall = 0;
    end
  end

  function automatic pw_t make_pw(input string s);
    pw_t p;
    for (int i = 0; i < 20; i++) p[i] = i < s.len() ? s[i] : 8'h20;
    return p;
  endfunction

  function automatic int last_nonpad(input pw_t p);
    int l = 0;
    for (int i = 0; i < 20; i++) if (p[i] != 8'h20) l = i + 1;
    return l;
  endfunction

  task automatic push_exp(input pw_t p);
    for (int i = 0; i < last_nonpad(p); i++) exp_q.push_back(p[i]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    match_found = 1;
    password_byte = b;
    while (!ack && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ack_seen", ack, 1);
    @(posedge clk); #1;
    match_found = 0;
    @(posedge clk); #1;
  endtask

  task automatic send_pw(input pw_t p);
    for (int i = 0; i < 20; i++) send_byte(p[i]);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || np_q.size() != 0 || busy) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_drained"}, exp_q.size() + np_q.size(), 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    pw_t p, q;
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {ack, tx_valid, tx_data, busy, match_count}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    p = make_pw("abc");
    push_exp(p);
    for (int i = 0; i < 20; i++) np_q.push_back(p[i]);
    np_q.push_back(8'h0A);
    c0 = ack_cnt;
    send_pw(p);
    chk("t1_ack_pulses", ack_cnt - c0, 20);
    drain("t1");
    chk("t1_match_count", match_count, 1);
    chk("t2_np_match_count", np_mc, 1);
    chk("t2_np_busy", np_busy, 0);
    np_en = 0;

    p = make_pw("a b");
    push_exp(p);
    tog_en = 1;
    send_pw(p);
    drain("t3");
    tog_en = 0;
    chk("t3_match_count", match_count, 2);

    p = make_pw("");
    push_exp(p);
    send_pw(p);
    drain("t4");
    chk("t4_match_count", match_count, 3);

    p = make_pw("hello");
    q = make_pw("wrld!");
    push_exp(p);
    rdy = 0;
    send_pw(p);
    match_found = 1;
    password_byte = q[0];
    c0 = ack_cnt;
    repeat (50) @(posedge clk);
    #1;
    chk("t5_no_ack_stalled", ack_cnt - c0, 0);
    chk("t5_stall_head", {tx_valid, tx_data, busy}, {1'b1, p[0], 1'b1});
    push_exp(q);
    rdy = 1;
    send_pw(q);
    drain("t5");
    chk("t5_match_count", match_count, 5);

    p = make_pw("qrstuvw");
    for (int i = 0; i < 5; i++) send_byte(p[i]);
    match_found = 1;
    password_byte = p[5];
    rst_n = 0;
    #1;
    chk("t6_async_rst", {ack, tx_valid, tx_data, busy, match_count}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    c0 = ack_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_ack_while_high", ack_cnt - c0, 0);
    chk("t6_idle_outputs", {tx_valid, tx_data, busy, match_count}, 0);
    match_found = 0;
    @(posedge clk); #1;
    p = make_pw("zz9");
    push_exp(p);
    c0 = ack_cnt;
    send_pw(p);
    chk("t6_ack_pulses", ack_cnt - c0, 20);
    drain("t6");
    chk("t6_match_count", match_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
